// File: rtl/spi_ram_controller_if.sv
// Command/response bus between the SPI slave and the RAM controller.
// Also exposes the controller's address pointers for debug.
interface spi_ram_controller_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 rx_valid;
    logic [9:0]           rx_data;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic                 cmd_err;

    modport master (
        output rx_valid, rx_data,
        input  tx_valid, tx_data, wr_ptr, rd_ptr, cmd_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output tx_valid, tx_data, wr_ptr, rd_ptr, cmd_err
    );
endinterface

// File: rtl/spi_ram_controller.sv
// Single-port byte RAM driven by 10-bit {cmd, payload} words from the SPI slave.
// Provides independent write/read pointers with optional post-access auto-increment.
module spi_ram_controller #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    spi_ram_controller_if.slave bus
);
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic [7:0]           mem [MEM_DEPTH];
    state_t               state;
    cmd_t                 cmd;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] wr_ptr_q;
    logic [ADDR_SIZE-1:0] rd_ptr_q;
    logic                 tx_valid_q;
    logic [7:0]           tx_data_q;
    logic                 cmd_err_q;

    always_comb begin
        cmd     = cmd_t'(bus.rx_data[9:8]);
        payload = bus.rx_data[7:0];
    end

    // Memory has no reset: contents survive rst and are undefined at power-up.
    always_ff @(posedge clk) begin
        if (bus.rx_valid && cmd == WR_DATA)
            mem[wr_ptr_q] <= payload;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            if (bus.rx_valid) begin
                case (cmd)
                    WR_ADDR: wr_ptr_q <= payload[ADDR_SIZE-1:0];
                    WR_DATA: begin
                        if (AUTO_INC)
                            wr_ptr_q <= wr_ptr_q + ADDR_SIZE'(1);
                    end
                    RD_ADDR: begin
                        rd_ptr_q <= payload[ADDR_SIZE-1:0];
                        state    <= ARMED;
                    end
                    RD_DATA: begin
                        if (state == ARMED) begin
                            tx_data_q  <= mem[rd_ptr_q];
                            tx_valid_q <= 1'b1;
                            if (AUTO_INC)
                                rd_ptr_q <= rd_ptr_q + ADDR_SIZE'(1);
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.wr_ptr   = wr_ptr_q;
    assign bus.rd_ptr   = rd_ptr_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.cmd_err  = cmd_err_q;
endmodule
